uart_cmd_bridge: RTL and testbench
==================================

// Module: uart_cmd_bridge
// PURPOSE
//  Consumes bytes from the UART receiver and decodes host command frames into single 32-bit bus transactions.
//  Returns status and read data to the host through the UART transmitter.
//  Sits between uart_rx/uart_tx and the System bus master port that reaches the SRAM controller.
//  Frames: WRITE = 0x56, A0..A3, D0..D3; READ = 0x55, A0..A3. Multi-byte fields are little-endian (byte 0 = bits 7:0).
// PARAMETERS
//  CMD_WRITE      8'h56      opcode for write frame
//  CMD_READ       8'h55      opcode for read frame
//  ACK_BYTE       8'hAA      byte returned after a completed write
//  TIMEOUT_CYCLES 1_000_000  idle clk cycles allowed between frame bytes (20 ms at 50 MHz)
// PORTS
//  clk50MHz   in   1   system clock, 50 MHz
//  reset      in   1   synchronous, active-high reset
//  rx_data    in   8   received byte, valid when rx_valid=1
//  rx_valid   in   1   one-cycle strobe per received byte
//  tx_data    out  8   byte to transmit, held stable while tx_start=1
//  tx_start   out  1   one-cycle strobe requesting transmission of tx_data
//  tx_busy    in   1   uart_tx busy; rises the cycle after tx_start
//  bus_req    out  1   bus request, held until bus_ack
//  bus_we     out  1   1 = write, 0 = read; valid while bus_req=1
//  bus_addr   out  32  transaction address
//  bus_wdata  out  32  write data
//  bus_rdata  in   32  read data, valid in the bus_ack cycle
//  bus_ack    in   1   one-cycle completion strobe
//  frame_err  out  1   one-cycle pulse on bad opcode, timeout or overrun
// BEHAVIOUR
//  Reset: state=IDLE; tx_start, bus_req, bus_we, frame_err = 0; tx_data, bus_addr, bus_wdata = 0; byte counter = 0; timeout counter = 0.
//  Reset mid-frame or mid-transaction drops everything: no bus_req and no tx_start may follow.
//  States:
//   IDLE:  rx_valid with CMD_WRITE -> ADDR(we=1); with CMD_READ -> ADDR(we=0); any other byte -> frame_err pulse, stay IDLE.
//   ADDR:  each rx_valid shifts rx_data into bus_addr[8*i+:8], i = 0..3. After the 4th byte -> DATA if we, else BUS.
//   DATA:  same scheme into bus_wdata. After the 4th byte -> BUS.
//   BUS:   bus_req=1 from the cycle after the last frame byte. In the bus_ack cycle, latch bus_rdata.
//          bus_req=0 the next cycle; go to TX.
//   TX:    write sends ACK_BYTE once; read sends rdata bytes 0..3 in order.
//          Issue tx_start only when tx_busy=0 and no tx_start was issued the previous cycle.
//          After the final byte is accepted (tx_busy observed low again) -> IDLE.
//  Bus_ack outside BUS is ignored. Bus_ack in the same cycle bus_req first rises is valid (zero-wait bus).
//  Timeout: in ADDR/DATA the counter increments each cycle without rx_valid and clears on rx_valid.
//   Reaching TIMEOUT_CYCLES -> frame_err pulse, IDLE, partial fields discarded.
//  Overrun: rx_valid in BUS or TX -> byte dropped, frame_err pulse, current operation continues.
//  Simultaneous rx_valid and timeout expiry: the byte wins and the counter clears.
//  No timeout in BUS; the bus owner guarantees an ack.
//  Latency: last frame byte -> bus_req = 1 cycle; bus_ack -> first tx_start = 2 cycles.
// TESTING
//  1. Write 56 01 00 00 00 | FF 00 FF 00 -> one bus_req with we=1, addr=0x00000001, wdata=0x00FF00FF; after ack, tx 0xAA once.
//  2. Read 55 01 00 00 00, bus_rdata=0x00FF00FF -> bus_req we=0, addr=0x00000001; tx FF,00,FF,00 in order, each gated by tx_busy.
//  3. Byte 0x42 in IDLE -> frame_err pulse, no bus_req; following valid write frame processed normally.
//  4. 56 then two address bytes, then silence > TIMEOUT_CYCLES (sim override 100) -> frame_err; next 55 frame decodes from byte 0.
//  5. rx_valid during TX of a read response -> frame_err pulse; all 4 response bytes still sent unchanged.
//  6. reset asserted while bus_req=1 -> next cycle bus_req=0, tx_start=0, state IDLE; late bus_ack ignored.

Source files
------------

// File: rtl/uart_cmd_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_bridge
//  Brief    : Decodes host command frames arriving from uart_rx into single
//             32-bit bus transactions. Write frames are answered with one
//             ACK byte and read frames with four little-endian data bytes,
//             both sent through uart_tx.
//             Frames: WRITE = CMD_WRITE A0..A3 D0..D3, READ = CMD_READ A0..A3.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_bridge #(
    parameter logic [7:0]  CMD_WRITE      = 8'h56,
    parameter logic [7:0]  CMD_READ       = 8'h55,
    parameter logic [7:0]  ACK_BYTE       = 8'hAA,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk50MHz,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        frame_err
);

    localparam int unsigned    TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    // Value the idle counter holds on the last idle cycle before expiry.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_BUS  = 3'd3,
        S_TX   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;          // field byte index, then tx byte count
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;    // idle cycles since last frame byte
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [31:0]       bus_addr_q, bus_addr_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              frame_err_q, frame_err_d;

    logic [4:0]        lane;                  // bit offset of the current byte lane
    logic [2:0]        tx_total;              // bytes in the response
    logic              tx_ready;              // uart_tx can take a new byte

    assign lane     = {cnt_q[1:0], 3'b000};
    assign tx_total = bus_we_q ? 3'd1 : 3'd4;
    // tx_busy only rises the cycle after tx_start, so the strobe cycle itself is excluded.
    assign tx_ready = !tx_busy && !tx_start_q;

    // State and output registers with synchronous reset.
    always_ff @(posedge clk50MHz) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            to_cnt_q    <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rdata_q     <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            to_cnt_q    <= to_cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Frame decode, bus handshake and response sequencing.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        to_cnt_d    = to_cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d    = '0;
                to_cnt_d = '0;
                if (rx_valid) begin
                    if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
                        bus_we_d    = (rx_data == CMD_WRITE);
                        bus_addr_d  = '0;
                        bus_wdata_d = '0;
                        state_d     = S_ADDR;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end

            S_ADDR, S_DATA: begin
                // A byte arriving on the expiry cycle wins over the timeout.
                if (rx_valid) begin
                    to_cnt_d = '0;
                    if (state_q == S_ADDR) begin
                        bus_addr_d[lane +: 8] = rx_data;
                    end else begin
                        bus_wdata_d[lane +: 8] = rx_data;
                    end
                    if (cnt_q == 3'd3) begin
                        cnt_d = '0;
                        if (state_q == S_ADDR && bus_we_q) begin
                            state_d = S_DATA;
                        end else begin
                            state_d   = S_BUS;
                            bus_req_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                    to_cnt_d    = '0;
                    bus_addr_d  = '0;
                    bus_wdata_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end

            S_BUS: begin
                if (rx_valid) begin
                    frame_err_d = 1'b1;
                end
                if (bus_ack) begin
                    rdata_d   = bus_rdata;
                    bus_req_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_TX;
                end
            end

            S_TX: begin
                if (rx_valid) begin
                    frame_err_d = 1'b1;
                end
                if (cnt_q < tx_total) begin
                    if (tx_ready) begin
                        tx_start_d = 1'b1;
                        tx_data_d  = bus_we_q ? ACK_BYTE : rdata_q[lane +: 8];
                        cnt_d      = cnt_q + 3'd1;
                    end
                end else if (tx_ready) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign tx_data   = tx_data_q;
    assign tx_start  = tx_start_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_cmd_bridge
//  Brief    : Self-checking bench for uart_cmd_bridge. Models uart_tx busy
//             behaviour and a bus slave with random wait states, applies a
//             table of frames, random frames and multi-cycle corner cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_bridge;

    localparam int TO = 100;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        frame_err;

    uart_cmd_bridge #(
        .CMD_WRITE      (8'h56),
        .CMD_READ       (8'h55),
        .ACK_BYTE       (8'hAA),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk50MHz  (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .frame_err (frame_err)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          ferr_cnt = 0;
    int          req_rise_cnt = 0;
    int          ack_seq  = 0;
    int          ack_cyc  = 0;
    int          last_rx_cyc = 0;
    int          late_req = 0;
    bit          hold_ack = 0;
    logic [31:0] rd_value = '0;

    logic [7:0]  tx_q[$];
    logic        txn_we_q[$];
    logic [31:0] txn_addr_q[$];
    logic [31:0] txn_wdata_q[$];

    typedef struct {
        string            name;
        int               nb;
        logic [0:8][7:0]  b;
        logic [31:0]      rdata;
        int               exp_txn;
        logic             exp_we;
        logic [31:0]      exp_addr;
        logic [31:0]      exp_wdata;
        int               exp_ntx;
        logic [0:3][7:0]  exp_tx;
        int               exp_ferr;
    } vec_t;

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // uart_tx model: busy rises the cycle after tx_start and lasts 1..5 cycles.
    initial begin
        int  busy_left  = 0;
        int  seen_seq   = 0;
        bit  start_prev = 0;
        bit  busy_before;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            busy_before = tx_busy;
            if (busy_left > 0) begin
                tx_busy = 1'b1;
                busy_left--;
            end else begin
                tx_busy = 1'b0;
            end
            if (tx_start === 1'b1) begin
                check("tx_gate_busy", 32'(busy_before), 32'd0);
                check("tx_gate_b2b", 32'(start_prev), 32'd0);
                tx_q.push_back(tx_data);
                if (ack_seq != seen_seq) begin
                    check("ack_to_tx_latency", 32'(cyc - ack_cyc), 32'd2);
                    seen_seq = ack_seq;
                end
                busy_left = $urandom_range(1, 5);
            end
            start_prev = (tx_start === 1'b1);
        end
    end

    // Bus slave model: 0..3 wait states, optional hold, and a stray late ack on request.
    initial begin
        bit acked    = 0;
        bit req_prev = 0;
        int delay    = 0;
        int late_done = 0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        forever begin
            @(negedge clk);
            bus_ack   = 1'b0;
            bus_rdata = $urandom;
            if (bus_req === 1'b1 && !req_prev) begin
                req_rise_cnt++;
                check("req_latency", 32'(cyc - last_rx_cyc), 32'd1);
            end
            if (late_req != late_done) begin
                bus_ack   = 1'b1;
                bus_rdata = 32'hBAD0BAD0;
                late_done++;
            end else if (bus_req === 1'b1 && !acked && !hold_ack) begin
                if (delay == 0) begin
                    bus_ack   = 1'b1;
                    bus_rdata = rd_value;
                    acked     = 1'b1;
                    txn_we_q.push_back(bus_we);
                    txn_addr_q.push_back(bus_addr);
                    txn_wdata_q.push_back(bus_wdata);
                    ack_cyc = cyc;
                    ack_seq++;
                end else begin
                    delay--;
                end
            end
            if (bus_req !== 1'b1) begin
                acked = 1'b0;
                delay = $urandom_range(0, 3);
            end
            req_prev = (bus_req === 1'b1);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (frame_err === 1'b1) ferr_cnt++;
        end
    end

    // Drives one byte for one cycle, then 'gap' idle cycles. Called right after a negedge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data     = b;
        rx_valid    = 1'b1;
        last_rx_cyc = cyc;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_tx(input int target, input string name);
        int n = 0;
        while (tx_q.size() < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, ":tx_done"}, 32'(tx_q.size() >= target), 32'd1);
        repeat (12) @(negedge clk);
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (bus_req !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, ":req_seen"}, 32'(bus_req), 32'd1);
    endtask

    // Sends a frame and compares bus transactions, response bytes and error pulses.
    task automatic run_and_check(input vec_t v, input int gap, input int tail);
        int tb = tx_q.size();
        int xb = txn_addr_q.size();
        int fb = ferr_cnt;
        rd_value = v.rdata;
        for (int k = 0; k < v.nb; k++) send_byte(v.b[k], gap);
        repeat (tail) @(negedge clk);
        if (v.exp_ntx > 0) wait_tx(tb + v.exp_ntx, v.name);
        else repeat (12) @(negedge clk);
        check({v.name, ":txn_cnt"}, 32'(txn_addr_q.size() - xb), 32'(v.exp_txn));
        if (v.exp_txn > 0 && txn_addr_q.size() > xb) begin
            check({v.name, ":we"}, 32'(txn_we_q[xb]), 32'(v.exp_we));
            check({v.name, ":addr"}, txn_addr_q[xb], v.exp_addr);
            if (v.exp_we) check({v.name, ":wdata"}, txn_wdata_q[xb], v.exp_wdata);
        end
        check({v.name, ":tx_cnt"}, 32'(tx_q.size() - tb), 32'(v.exp_ntx));
        for (int j = 0; j < v.exp_ntx; j++) begin
            if (tb + j < tx_q.size()) check({v.name, ":tx_byte"}, 32'(tx_q[tb + j]), 32'(v.exp_tx[j]));
        end
        check({v.name, ":ferr"}, 32'(ferr_cnt - fb), 32'(v.exp_ferr));
    endtask

    initial begin
        vec_t vt[6];
        vec_t v;
        int   tb0, fb0, xb0, rb0;

        vt[0] = '{"write_t1", 9, {8'h56,8'h01,8'h00,8'h00,8'h00,8'hFF,8'h00,8'hFF,8'h00}, 32'h0,
                  1, 1'b1, 32'h00000001, 32'h00FF00FF, 1, {8'hAA,8'h00,8'h00,8'h00}, 0};
        vt[1] = '{"read_t2", 5, {8'h55,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 32'h00FF00FF,
                  1, 1'b0, 32'h00000001, 32'h0, 4, {8'hFF,8'h00,8'hFF,8'h00}, 0};
        vt[2] = '{"badop_42", 1, {8'h42,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 32'h0,
                  0, 1'b0, 32'h0, 32'h0, 0, {8'h00,8'h00,8'h00,8'h00}, 1};
        vt[3] = '{"write_le", 9, {8'h56,8'h78,8'h56,8'h34,8'h12,8'hEF,8'hBE,8'hAD,8'hDE}, 32'h0,
                  1, 1'b1, 32'h12345678, 32'hDEADBEEF, 1, {8'hAA,8'h00,8'h00,8'h00}, 0};
        vt[4] = '{"read_le", 5, {8'h55,8'h04,8'h03,8'h02,8'h01,8'h00,8'h00,8'h00,8'h00}, 32'hA1B2C3D4,
                  1, 1'b0, 32'h01020304, 32'h0, 4, {8'hD4,8'hC3,8'hB2,8'hA1}, 0};
        vt[5] = '{"badop_57", 1, {8'h57,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 32'h0,
                  0, 1'b0, 32'h0, 32'h0, 0, {8'h00,8'h00,8'h00,8'h00}, 1};

        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst:tx_start", 32'(tx_start), 32'd0);
        check("rst:tx_data", 32'(tx_data), 32'd0);
        check("rst:bus_req", 32'(bus_req), 32'd0);
        check("rst:bus_we", 32'(bus_we), 32'd0);
        check("rst:bus_addr", bus_addr, 32'd0);
        check("rst:bus_wdata", bus_wdata, 32'd0);
        check("rst:frame_err", 32'(frame_err), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) run_and_check(vt[i], i % 3, 0);

        // Byte arriving exactly on the expiry cycle keeps the frame alive.
        v = vt[3];
        v.name = "byte_wins";
        run_and_check(v, TO - 1, 0);

        // Exactly TIMEOUT_CYCLES idle cycles after the opcode expire the frame.
        v = vt[2];
        v.name = "to_exact";
        v.b[0] = 8'h56;
        run_and_check(v, TO, 0);

        // Partial write frame then long silence; a following read decodes from byte 0.
        v = vt[2];
        v.name = "to_partial";
        v.nb = 3;
        v.b = {8'h56,8'h11,8'h22,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
        run_and_check(v, 1, TO + 50);
        v = vt[1];
        v.name = "after_to_read";
        v.b = {8'h55,8'h21,8'h43,8'h65,8'h87,8'h00,8'h00,8'h00,8'h00};
        v.exp_addr = 32'h87654321;
        v.rdata = 32'h0BADCAFE;
        v.exp_tx = {8'hFE,8'hCA,8'hAD,8'h0B};
        run_and_check(v, 0, 0);

        // Overrun while the read response is being sent.
        tb0 = tx_q.size();
        fb0 = ferr_cnt;
        xb0 = txn_addr_q.size();
        rd_value = 32'h11223344;
        send_byte(8'h55, 0); send_byte(8'h00, 0); send_byte(8'h10, 0);
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        begin
            int n = 0;
            while (tx_q.size() <= tb0 && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        send_byte(8'h56, 0);
        wait_tx(tb0 + 4, "ovr_tx");
        check("ovr_tx:tx_cnt", 32'(tx_q.size() - tb0), 32'd4);
        for (int j = 0; j < 4; j++) begin
            if (tb0 + j < tx_q.size()) check("ovr_tx:tx_byte", 32'(tx_q[tb0 + j]), 32'((32'h11223344 >> (8 * j)) & 32'hFF));
        end
        check("ovr_tx:ferr", 32'(ferr_cnt - fb0), 32'd1);
        check("ovr_tx:txn_cnt", 32'(txn_addr_q.size() - xb0), 32'd1);

        // Overrun while waiting for the bus.
        tb0 = tx_q.size();
        fb0 = ferr_cnt;
        hold_ack = 1'b1;
        rd_value = 32'hCAFEF00D;
        send_byte(8'h55, 0); send_byte(8'h04, 0); send_byte(8'h00, 0);
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        wait_req("ovr_bus");
        send_byte(8'h99, 2);
        hold_ack = 1'b0;
        wait_tx(tb0 + 4, "ovr_bus");
        for (int j = 0; j < 4; j++) begin
            if (tb0 + j < tx_q.size()) check("ovr_bus:tx_byte", 32'(tx_q[tb0 + j]), 32'((32'hCAFEF00D >> (8 * j)) & 32'hFF));
        end
        check("ovr_bus:ferr", 32'(ferr_cnt - fb0), 32'd1);

        // Reset during an outstanding bus request; a late ack must be ignored.
        hold_ack = 1'b1;
        send_byte(8'h55, 0); send_byte(8'h08, 0); send_byte(8'h00, 0);
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        wait_req("rst_bus");
        reset = 1'b1;
        @(negedge clk);
        check("rst_bus:bus_req", 32'(bus_req), 32'd0);
        check("rst_bus:tx_start", 32'(tx_start), 32'd0);
        check("rst_bus:bus_addr", bus_addr, 32'd0);
        reset    = 1'b0;
        hold_ack = 1'b0;
        rb0 = req_rise_cnt;
        tb0 = tx_q.size();
        late_req++;
        repeat (30) @(negedge clk);
        check("rst_bus:no_req", 32'(req_rise_cnt - rb0), 32'd0);
        check("rst_bus:no_tx", 32'(tx_q.size() - tb0), 32'd0);
        v = vt[0];
        v.name = "after_rst_write";
        run_and_check(v, 1, 0);

        // Random frames against a frame-level model.
        for (int it = 0; it < 40; it++) begin
            int          kind = $urandom_range(0, 3);
            logic [31:0] a    = $urandom;
            logic [31:0] d    = $urandom;
            logic [31:0] r    = $urandom;
            int          tail = 0;
            v = vt[2];
            v.name  = $sformatf("rand%0d_k%0d", it, kind);
            v.b     = '0;
            v.rdata = r;
            v.exp_tx = '0;
            case (kind)
                0: begin
                    v.nb = 9; v.b[0] = 8'h56;
                    for (int j = 0; j < 4; j++) begin
                        v.b[1 + j] = 8'((a >> (8 * j)) & 32'hFF);
                        v.b[5 + j] = 8'((d >> (8 * j)) & 32'hFF);
                    end
                    v.exp_txn = 1; v.exp_we = 1'b1; v.exp_addr = a; v.exp_wdata = d;
                    v.exp_ntx = 1; v.exp_tx[0] = 8'hAA; v.exp_ferr = 0;
                end
                1: begin
                    v.nb = 5; v.b[0] = 8'h55;
                    for (int j = 0; j < 4; j++) begin
                        v.b[1 + j]   = 8'((a >> (8 * j)) & 32'hFF);
                        v.exp_tx[j]  = 8'((r >> (8 * j)) & 32'hFF);
                    end
                    v.exp_txn = 1; v.exp_we = 1'b0; v.exp_addr = a;
                    v.exp_ntx = 4; v.exp_ferr = 0;
                end
                2: begin
                    logic [7:0] bad;
                    do bad = 8'($urandom); while (bad == 8'h55 || bad == 8'h56);
                    v.nb = 1; v.b[0] = bad;
                    v.exp_txn = 0; v.exp_ntx = 0; v.exp_ferr = 1;
                end
                default: begin
                    bit wr = $urandom_range(0, 1) == 1;
                    v.b[0] = wr ? 8'h56 : 8'h55;
                    v.nb = 1 + $urandom_range(0, wr ? 7 : 3);
                    for (int j = 1; j < v.nb; j++) v.b[j] = 8'($urandom);
                    v.exp_txn = 0; v.exp_ntx = 0; v.exp_ferr = 1;
                    tail = TO + 30;
                end
            endcase
            run_and_check(v, $urandom_range(0, 3), tail);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
